// File: rtl/dispatch_pkg.sv
// Shared dispatch types: tag width, tag pool size, tag type and arbiter FSM states.
package dispatch_pkg;

   localparam int unsigned TAG_W    = 6;
   localparam int unsigned NUM_TAGS = 64;

   typedef logic [TAG_W-1:0] tag_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/tag_ring.sv
// Circular tag store: head is the next tag to hand out, tail is where returned tags land.
module tag_ring #(
   parameter int unsigned NUM_TAGS = 64,
   parameter int unsigned TAG_W    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [TAG_W-1:0] push_tag,
   input  logic             pop,
   output logic [TAG_W-1:0] head_tag
);

   localparam logic [TAG_W-1:0] LAST = TAG_W'(NUM_TAGS - 1);

   logic [TAG_W-1:0] mem [NUM_TAGS];
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;

   // Pointers wrap explicitly so non-power-of-two pool sizes work.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (push) tail <= (tail == LAST) ? '0 : tail + TAG_W'(1);
         if (pop)  head <= (head == LAST) ? '0 : head + TAG_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst && !clear) mem[tail] <= push_tag;
   end

   assign head_tag = mem[head];

endmodule

// File: rtl/tag_arbiter.sv
// Round-robin tag allocator over a FIFO tag pool with CDB tag return and flush re-init.
// Optional stall statistics counter enabled by defining TAG_ARB_STATS_EN.
module tag_arbiter
   import dispatch_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned NUM_TAGS = dispatch_pkg::NUM_TAGS,
   parameter int unsigned TAG_W    = dispatch_pkg::TAG_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_grant,
   output logic [TAG_W-1:0]   grant_tag,
   input  logic               cdb_valid,
   input  logic [TAG_W-1:0]   cdb_tag,
   input  logic               flush,
   output logic               ready,
   output logic [TAG_W:0]     free_count,
   output logic               overflow_err,
   output logic [15:0]        stall_cnt
);

   localparam int unsigned   RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [TAG_W:0] FULL = (TAG_W+1)'(NUM_TAGS);

   arb_state_t        state;
   logic [TAG_W-1:0]  init_cnt;
   logic [RR_W-1:0]   rr_ptr;
   logic [RR_W-1:0]   grant_idx;
   logic [RR_W-1:0]   scan_idx;
   int unsigned       rr_sum;
   logic              found;
   logic              can_grant;
   logic              do_grant;
   logic              do_ret;
   logic              accept_ret;
   logic              ring_push;
   logic [TAG_W-1:0]  ring_push_tag;
   logic [TAG_W-1:0]  head_tag;

   assign can_grant = (state == ST_RUN) && (free_count != '0) && !flush;

   // First asserted requester at or after rr_ptr, wrapping.
   always_comb begin
      found     = 1'b0;
      grant_idx = rr_ptr;
      scan_idx  = '0;
      rr_sum    = 0;
      req_grant = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         rr_sum = 32'(rr_ptr) + k;
         if (rr_sum >= NUM_REQ) rr_sum = rr_sum - NUM_REQ;
         scan_idx = RR_W'(rr_sum);
         if (!found && req_valid[scan_idx]) begin
            found     = 1'b1;
            grant_idx = scan_idx;
         end
      end
      if (can_grant && found) req_grant[grant_idx] = 1'b1;
   end

   assign do_grant      = can_grant && found;
   assign do_ret        = (state == ST_RUN) && cdb_valid && !flush;
   assign accept_ret    = do_ret && ((free_count != FULL) || do_grant);
   assign ring_push     = ((state == ST_INIT) && !flush) || accept_ret;
   assign ring_push_tag = (state == ST_INIT) ? init_cnt : cdb_tag;
   assign grant_tag     = (|req_grant) ? head_tag : '0;
   assign ready         = (state == ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_INIT;
         init_cnt     <= '0;
         free_count   <= '0;
         rr_ptr       <= '0;
         overflow_err <= 1'b0;
      end else if (flush) begin
         state      <= ST_INIT;
         init_cnt   <= '0;
         free_count <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt   <= init_cnt + TAG_W'(1);
               free_count <= free_count + (TAG_W+1)'(1);
               if (init_cnt == TAG_W'(NUM_TAGS - 1)) state <= ST_RUN;
            end
            ST_RUN: begin
               if (do_grant)
                  rr_ptr <= (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + RR_W'(1);
               if (do_grant && !accept_ret)
                  free_count <= free_count - (TAG_W+1)'(1);
               else if (!do_grant && accept_ret)
                  free_count <= free_count + (TAG_W+1)'(1);
               if (do_ret && !accept_ret) overflow_err <= 1'b1;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

`ifdef TAG_ARB_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst)
         stall_q <= '0;
      else if ((state == ST_RUN) && (|req_valid) && (free_count == '0) && (stall_q != 16'hFFFF))
         stall_q <= stall_q + 16'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

   tag_ring #(
      .NUM_TAGS (NUM_TAGS),
      .TAG_W    (TAG_W)
   ) u_ring (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .push     (ring_push),
      .push_tag (ring_push_tag),
      .pop      (do_grant),
      .head_tag (head_tag)
   );

endmodule

// File: tb/tb_tag_arbiter.sv
// Bench for tag_arbiter: queue-based pool model checked every cycle plus directed literal checks.
// Stall expectations follow TAG_ARB_STATS_EN.
module tb_tag_arbiter;
   import dispatch_pkg::*;

   localparam int NREQ = 4;
   localparam int NT   = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_grant;
   logic [5:0]      grant_tag;
   logic            cdb_valid;
   logic [5:0]      cdb_tag;
   logic            flush;
   logic            ready;
   logic [6:0]      free_count;
   logic            overflow_err;
   logic [15:0]     stall_cnt;

   int n_vec  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   // Model state: pool contents in hand-out order
   tag_t m_pool[$];
   bit   m_init  = 1;
   int   m_rr    = 0;
   bit   m_ovf   = 0;
   int   m_stall = 0;

   tag_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_grant    (req_grant),
      .grant_tag    (grant_tag),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .flush        (flush),
      .ready        (ready),
      .free_count   (free_count),
      .overflow_err (overflow_err),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Compare against the model, then advance the model by one clock
   always @(negedge clk) begin
      if (chk_en) begin
         int   gi;
         int   idx;
         bit   was_full;
         logic [NREQ-1:0] eg;
         logic [5:0]      et;
         gi = -1;
         eg = '0;
         et = '0;
         if (!m_init && m_pool.size() > 0 && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
               idx = (m_rr + k) % NREQ;
               if (gi < 0 && req_valid[idx]) gi = idx;
            end
         end
         if (gi >= 0) begin
            eg[gi] = 1'b1;
            et     = m_pool[0];
         end
         chk("req_grant", 64'(req_grant), 64'(eg));
         chk("grant_tag", 64'(grant_tag), 64'(et));
         chk("free_count", 64'(free_count), 64'(m_pool.size()));
         chk("ready", 64'(ready), 64'(!m_init));
         chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
         chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));

         if (rst) begin
            m_pool.delete();
            m_init  = 1;
            m_rr    = 0;
            m_ovf   = 0;
            m_stall = 0;
         end else begin
`ifdef TAG_ARB_STATS_EN
            if (!m_init && (|req_valid) && m_pool.size() == 0 && m_stall < 65535) m_stall++;
`endif
            if (flush) begin
               m_pool.delete();
               m_init = 1;
            end else if (m_init) begin
               m_pool.push_back(tag_t'(m_pool.size()));
               if (m_pool.size() == NT) m_init = 0;
            end else begin
               was_full = (m_pool.size() == NT);
               if (gi >= 0) begin
                  void'(m_pool.pop_front());
                  m_rr = (gi + 1) % NREQ;
               end
               if (cdb_valid) begin
                  if (was_full && gi < 0) m_ovf = 1;
                  else m_pool.push_back(cdb_tag);
               end
            end
         end
      end
   end

   initial begin
      rst = 1; req_valid = '0; cdb_valid = 0; cdb_tag = '0; flush = 0;
      cyc();
      chk_en = 1;
      cyc();
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_free", 64'(free_count), 64'd0);
      chk("rst_tag", 64'(grant_tag), 64'd0);
      chk("rst_ovf", 64'(overflow_err), 64'd0);
      chk("rst_stall", 64'(stall_cnt), 64'd0);

      // Init takes exactly NUM_TAGS cycles
      rst = 0;
      repeat (63) cyc();
      chk("init63_ready", 64'(ready), 64'd0);
      chk("init63_free", 64'(free_count), 64'd63);
      cyc();
      chk("init64_ready", 64'(ready), 64'd1);
      chk("init64_free", 64'(free_count), 64'd64);

      // Round robin with all requesting
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_grant", 64'(req_grant), 64'(1 << i));
         chk("rr_tag", 64'(grant_tag), 64'(i));
         cyc();
      end
      req_valid = '0;
      #1 chk("rr_free", 64'(free_count), 64'd60);

      // Drain, then a return on an empty pool is not bypassed
      req_valid = 4'b0001;
      repeat (60) cyc();
      chk("drain_free", 64'(free_count), 64'd0);
      cdb_valid = 1; cdb_tag = 6'd5;
      #1 chk("nobypass_grant", 64'(req_grant), 64'd0);
      cyc();
      cdb_valid = 0;
      #1;
      chk("bypass_next_grant", 64'(req_grant), 64'b0001);
      chk("bypass_next_tag", 64'(grant_tag), 64'd5);
      cyc();

      // Stall statistics on an empty pool
      repeat (20) cyc();
      req_valid = '0;
`ifdef TAG_ARB_STATS_EN
      chk("stall_cnt20", 64'(stall_cnt), 64'd21);
`else
      chk("stall_cnt20", 64'(stall_cnt), 64'd0);
`endif

      // Refill with 10 tags, then grant and return together
      for (int i = 10; i < 20; i++) begin
         cdb_valid = 1; cdb_tag = 6'(i);
         cyc();
      end
      cdb_valid = 0;
      chk("refill_free", 64'(free_count), 64'd10);
      req_valid = 4'b0001; cdb_valid = 1; cdb_tag = 6'd9;
      #1 chk("simul_tag", 64'(grant_tag), 64'd10);
      cyc();
      cdb_valid = 0;
      chk("simul_free", 64'(free_count), 64'd10);
      repeat (9) cyc();
      chk("tail_tag9", 64'(grant_tag), 64'd9);
      cyc();
      req_valid = '0;

      // Flush in RUN, re-init, overflow on full pool
      flush = 1;
      cyc();
      flush = 0;
      chk("flush_ready", 64'(ready), 64'd0);
      chk("flush_free", 64'(free_count), 64'd0);
      repeat (63) cyc();
      chk("flush63_ready", 64'(ready), 64'd0);
      cyc();
      chk("flush64_ready", 64'(ready), 64'd1);
      chk("flush64_free", 64'(free_count), 64'd64);
      cdb_valid = 1; cdb_tag = 6'd7;
      cyc();
      cdb_valid = 0;
      chk("ovf_set", 64'(overflow_err), 64'd1);
      chk("ovf_free", 64'(free_count), 64'd64);
      req_valid = 4'b0001; cdb_valid = 1; cdb_tag = 6'd7;
      #1 chk("post_flush_tag", 64'(grant_tag), 64'd0);
      cyc();
      req_valid = '0; cdb_valid = 0;
      chk("full_simul_free", 64'(free_count), 64'd64);
      chk("ovf_sticky", 64'(overflow_err), 64'd1);
      req_valid = 4'b1010;
      #1 chk("rr_skip_grant", 64'(req_grant), 64'b0010);
      repeat (4) cyc();
      req_valid = '0;

      // Flush during INIT restarts the count
      flush = 1;
      cyc();
      flush = 0;
      repeat (10) cyc();
      chk("init_partial_free", 64'(free_count), 64'd10);
      flush = 1;
      cyc();
      flush = 0;
      chk("init_reflush_free", 64'(free_count), 64'd0);
      repeat (64) cyc();
      chk("reinit_ready", 64'(ready), 64'd1);

      // Reset mid-operation
      req_valid = 4'b0011;
      repeat (3) cyc();
      req_valid = '0; rst = 1;
      repeat (2) cyc();
      rst = 0;
      chk("mid_rst_ovf", 64'(overflow_err), 64'd0);
      chk("mid_rst_free", 64'(free_count), 64'd0);
      chk("mid_rst_stall", 64'(stall_cnt), 64'd0);
      repeat (64) cyc();
      chk("mid_rst_ready", 64'(ready), 64'd1);
      req_valid = 4'b0100;
      #1;
      chk("mid_rst_grant", 64'(req_grant), 64'b0100);
      chk("mid_rst_tag", 64'(grant_tag), 64'd0);
      cyc();
      req_valid = '0;
      cyc();

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/tag_arbiter.md
TAG_ARBITER -- requirements
Module: tag_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of dispatch requesters.
REQ-002 SHALL have parameter NUM_TAGS, default 64, size of the tag pool.
REQ-003 SHALL have parameter TAG_W, default 6, tag width; NUM_TAGS <= 2**TAG_W.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester tag request, held until granted.
REQ-008 SHALL have port req_grant  output  NUM_REQ  one-hot grant, combinational, same cycle.
REQ-009 SHALL have port grant_tag  output  TAG_W  tag delivered with req_grant.
REQ-010 SHALL have port cdb_valid  input  1  CDB broadcast, tag returns to pool.
REQ-011 SHALL have port cdb_tag  input  TAG_W  returned tag.
REQ-012 SHALL have port flush  input  1  reclaim all tags, re-initialise pool.
REQ-013 SHALL have port ready  output  1  pool initialised, grants possible.
REQ-014 SHALL have port free_count  output  TAG_W+1  tags currently in pool.
REQ-015 SHALL have port overflow_err  output  1  sticky: return attempted with pool full.
REQ-016 SHALL have port stall_cnt  output  16  request-stall statistics (see Configuration).

Function
REQ-017 SHALL implement FSM states INIT and RUN; RUN->INIT on flush, INIT->RUN when init counter reaches NUM_TAGS-1.
REQ-018 SHALL, in INIT, write tag i into ring slot i at init count i, one per cycle, free_count incrementing by 1; exactly NUM_TAGS cycles.
REQ-019 SHALL hold ready=0, req_grant=0 and ignore cdb_valid while in INIT.
REQ-020 SHALL, in RUN with free_count>0, grant exactly one asserted requester per cycle, round-robin starting at rr_ptr; rr_ptr then becomes granted index+1 modulo NUM_REQ.
REQ-021 SHALL drive grant_tag from ring head; on grant, the head pointer advances and free_count decrements at the clock edge.
REQ-022 SHALL hand out tags in FIFO order: 0,1,2,... after init, then returned tags in return order.
REQ-023 SHALL append cdb_tag at ring tail on cdb_valid in RUN, incrementing free_count.
REQ-024 SHALL, on simultaneous grant and return, perform both, leaving free_count unchanged.
REQ-025 SHALL, with free_count==0, assert no grant even if cdb_valid is high that cycle (no bypass); the tag is grantable next cycle.
REQ-026 SHALL, on return with free_count==NUM_TAGS and no grant, drop the tag and set overflow_err until reset.
REQ-027 SHALL wrap head/tail pointers modulo NUM_TAGS.
REQ-028 SHALL, on flush in INIT, restart the init counter at 0 with free_count=0; flush has priority over grant and return.

Reset
REQ-029 SHALL, on rst, set state=INIT, init counter=0, head=tail=0, rr_ptr=0, free_count=0, ready=0, req_grant=0, grant_tag=0, overflow_err=0, stall_cnt=0.
REQ-030 SHALL, on rst mid-operation, discard all pool contents and re-run INIT; ready rises NUM_TAGS cycles after rst deasserts.

Configuration
REQ-031 SHALL, with TAG_ARB_STATS_EN defined, increment stall_cnt (saturating at 16'hFFFF) each RUN cycle where any req_valid is high and free_count==0; cleared by rst only.
REQ-032 SHALL, without TAG_ARB_STATS_EN, tie stall_cnt to 0 and synthesise no counter.

Structure
REQ-033 SHALL take TAG_W, NUM_TAGS, typedef tag_t and the FSM state enum from shared package dispatch_pkg.
REQ-034 SHALL place ring storage and head/tail pointers in sub-module tag_ring; arbitration, FSM and counters stay in tag_arbiter.

Verification
REQ-035 SHALL verify: rst then idle 64 cycles -> ready=0 through cycle 63, ready=1 and free_count=64 at cycle 64.
REQ-036 SHALL verify: req_valid=4'b1111 for 4 cycles after ready -> grants 0001,0010,0100,1000 with tags 0,1,2,3; free_count=60.
REQ-037 SHALL verify: drain all 64 tags, then cdb_valid with tag 5 while req_valid=1 -> no grant that cycle, grant_tag=5 next cycle.
REQ-038 SHALL verify: grant plus cdb_valid tag 9 same cycle at free_count=10 -> free_count stays 10, tag 9 at tail.
REQ-039 SHALL verify: cdb_valid with pool full -> overflow_err=1 and free_count=64 held; flush mid-RUN -> ready=0, 64 cycles later free_count=64, next grant tag=0.
REQ-040 SHALL verify, with TAG_ARB_STATS_EN: empty pool plus req_valid for 20 cycles -> stall_cnt=20; without the macro stall_cnt=0.
